// File: rtl/clip_scheduler_pkg.sv
// Shared constants, FSM encoding and vertex-field helpers for the clipper front-end.
package clip_pkg;

  localparam int COORD_W      = 32;
  localparam int TRI_W        = 12 * COORD_W;
  localparam int CLIP_LATENCY = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_CAPT = 2'd2
  } state_e;

  // Field idx 0 is v0_x (MSBs); idx = 4*vertex + {x,y,z,w}.
  function automatic logic [COORD_W-1:0] get_coord(input logic [TRI_W-1:0] t,
                                                   input int unsigned idx);
    return t[TRI_W-1-idx*COORD_W -: COORD_W];
  endfunction

  function automatic logic [TRI_W-1:0] set_coord(input logic [TRI_W-1:0] t,
                                                 input int unsigned idx,
                                                 input logic [COORD_W-1:0] v);
    logic [TRI_W-1:0] r;
    r = t;
    r[TRI_W-1-idx*COORD_W -: COORD_W] = v;
    return r;
  endfunction

endpackage

// File: rtl/clip_scheduler_if.sv
// Triangle buses around the scheduler: upstream input, clipper side and rasterizer output.
interface clip_scheduler_if #(
  parameter int COORD_W = 32
);
  localparam int TRI_W = 12 * COORD_W;

  logic             in_valid;
  logic             in_ready;
  logic [TRI_W-1:0] in_tri;
  logic             clip_valid_in;
  logic [TRI_W-1:0] clip_tri;
  logic             clip_valid_out;
  logic [2:0]       clip_vertex_count;
  logic [TRI_W-1:0] clip_res_tri;
  logic             out_valid;
  logic             out_ready;
  logic [TRI_W-1:0] out_tri;

  modport master (
    output in_valid, in_tri, clip_valid_out, clip_vertex_count, clip_res_tri, out_ready,
    input  in_ready, clip_valid_in, clip_tri, out_valid, out_tri
  );

  modport slave (
    input  in_valid, in_tri, clip_valid_out, clip_vertex_count, clip_res_tri, out_ready,
    output in_ready, clip_valid_in, clip_tri, out_valid, out_tri
  );
endinterface

// File: rtl/clip_scheduler_tri_fifo.sv
// Small synchronous FIFO holding whole triangles; head is the oldest entry.
module tri_fifo #(
  parameter int WIDTH = 384,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end
endmodule

// File: rtl/clip_scheduler.sv
// Issues buffered triangles to the latency-fixed clipper, captures surviving results
// and forwards them to the rasterizer over valid/ready; keeps per-frame statistics.
//   state  | meaning
//   S_IDLE | nothing in the clipper; issue as soon as the FIFO has a triangle
//   S_BUSY | clipper working; count down its fixed latency
//   S_CAPT | clipper result fresh; capture when the output register is free
module clip_scheduler #(
  parameter int COORD_W      = clip_pkg::COORD_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLIP_LATENCY = clip_pkg::CLIP_LATENCY,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  clip_scheduler_if.slave  bus,
  input  logic             stat_clr,
  output logic             busy,
  output logic [CNT_W-1:0] stat_in,
  output logic [CNT_W-1:0] stat_out,
  output logic [CNT_W-1:0] stat_cull
);
  import clip_pkg::*;

  localparam int TRI_W = 12 * COORD_W;
  localparam int CW    = $clog2(CLIP_LATENCY + 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             clip_valid_in_q, out_valid_q;
  logic [TRI_W-1:0] clip_tri_q, out_tri_q;
  logic [CNT_W-1:0] stat_in_q, stat_out_q, stat_cull_q;

  logic             fifo_full, fifo_empty;
  logic [TRI_W-1:0] fifo_head;
  logic             push, out_hs, capt_go, keep, issue;

  tri_fifo #(.WIDTH(TRI_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.in_tri),
    .pop   (issue),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign push    = bus.in_valid && !fifo_full;
  assign out_hs  = out_valid_q && bus.out_ready;
  assign capt_go = (state_q == S_CAPT) && (!out_valid_q || bus.out_ready);
  assign keep    = bus.clip_valid_out && (bus.clip_vertex_count == 3'd3);
  assign issue   = !fifo_empty && ((state_q == S_IDLE) || capt_go);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      clip_valid_in_q <= 1'b0;
      clip_tri_q      <= '0;
      out_valid_q     <= 1'b0;
      out_tri_q       <= '0;
    end else begin
      clip_valid_in_q <= issue;
      if (issue) begin
        clip_tri_q <= fifo_head;
        cnt_q      <= CW'(CLIP_LATENCY - 1);
      end
      case (state_q)
        S_IDLE:  if (issue) state_q <= S_BUSY;
        S_BUSY:  if (cnt_q == '0) state_q <= S_CAPT;
                 else cnt_q <= cnt_q - 1'b1;
        S_CAPT:  if (capt_go) state_q <= issue ? S_BUSY : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // Drain and reload may coincide; the reload wins.
      if (out_hs) out_valid_q <= 1'b0;
      if (capt_go && keep) begin
        out_valid_q <= 1'b1;
        out_tri_q   <= bus.clip_res_tri;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_in_q   <= '0;
      stat_out_q  <= '0;
      stat_cull_q <= '0;
    end else if (stat_clr) begin
      stat_in_q   <= '0;
      stat_out_q  <= '0;
      stat_cull_q <= '0;
    end else begin
      if (push)             stat_in_q   <= stat_in_q + 1'b1;
      if (out_hs)           stat_out_q  <= stat_out_q + 1'b1;
      if (capt_go && !keep) stat_cull_q <= stat_cull_q + 1'b1;
    end
  end

  assign bus.in_ready      = !fifo_full;
  assign bus.clip_valid_in = clip_valid_in_q;
  assign bus.clip_tri      = clip_tri_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_tri       = out_tri_q;
  assign busy              = !fifo_empty || (state_q != S_IDLE) || out_valid_q;
  assign stat_in           = stat_in_q;
  assign stat_out          = stat_out_q;
  assign stat_cull         = stat_cull_q;
endmodule

// File: doc/clip_scheduler.md
Name: clip_scheduler

Overview:
Sequencing controller in front of clipping_unit, which has no ready handshake. Buffers triangles from the vertex/primitive-assembly stage in a small FIFO and issues them to the clipper one at a time, with one-cycle valid_in pulses spaced by the clipper's fixed latency. Samples the clipper's result at the exact completion cycle, drops culled/degenerate results, and forwards surviving triangles to the rasterizer over valid/ready. Keeps per-frame statistics.

Parameters:
COORD_W, 32, width of one vertex coordinate
FIFO_DEPTH, 4, input triangle FIFO entries (power of 2, >=2)
CLIP_LATENCY, 7, clock edges from clipper accepting valid_in to its result registers being updated
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream triangle valid
in_ready  out  1  FIFO not full
in_tri  in  12*COORD_W  {v0 x,y,z,w, v1 x,y,z,w, v2 x,y,z,w}, v0_x in the MSBs
clip_valid_in  out  1  one-cycle issue pulse to clipper
clip_tri  out  12*COORD_W  triangle driven to the clipper's v0..v2 inputs, same packing
clip_valid_out  in  1  clipper valid_out (level is meaningful only in the capture cycle)
clip_vertex_count  in  3  clipper vertex_count
clip_res_tri  in  12*COORD_W  clipper out_v0..out_v2, same packing
out_valid  out  1  result triangle valid to rasterizer
out_ready  in  1  rasterizer accepts
out_tri  out  12*COORD_W  result triangle
busy  out  1  FIFO non-empty, or state != S_IDLE, or out_valid
stat_in  out  CNT_W  triangles accepted, wrapping
stat_out  out  CNT_W  triangles emitted, wrapping
stat_cull  out  CNT_W  triangles dropped, wrapping
stat_clr  in  1  synchronous clear of all stat counters; takes priority over same-cycle increments

Behaviour:
- Reset: state S_IDLE; FIFO empty; in_ready=1; clip_valid_in=0; clip_tri=0; out_valid=0; out_tri=0; stat_* = 0. clipping_unit shares rst, so reset mid-operation aborts both blocks cleanly and discards any in-flight triangle.
- FIFO: push when in_valid && in_ready; pop on issue. Simultaneous push and pop while full is not possible, because in_ready=0 when full. Simultaneous push and pop at any other occupancy keeps the count unchanged. Pointers wrap modulo FIFO_DEPTH. Order is preserved.
- S_IDLE: if FIFO not empty, assert clip_valid_in=1 for this cycle with clip_tri = FIFO head; pop; load cnt = CLIP_LATENCY-1; go to S_BUSY.
- clip_tri is registered from the FIFO head and held between issues. clip_valid_in is never high two consecutive cycles.
- S_BUSY: cnt decrements each edge; when cnt==0, go to S_CAPT. The first S_CAPT cycle therefore follows the CLIP_LATENCY-th edge after the issue edge, when the clipper's outputs are fresh and it is back in its idle state.
- S_CAPT: the capture succeeds if out_valid==0 or out_ready==1. On success:
  - if clip_valid_out==1 && clip_vertex_count==3: load out_tri=clip_res_tri, set out_valid=1, and increment stat_out when that triangle handshakes;
  - otherwise: increment stat_cull and load nothing.
  - Then, if the FIFO is non-empty, issue the next triangle in this same cycle (S_IDLE issue rules) and go to S_BUSY; else go to S_IDLE.
- S_CAPT stall: if out_valid==1 && out_ready==0, hold in S_CAPT with no issue. This is safe because the clipper's output registers hold until its next output cycle.
- Output: out_valid/out_tri stay stable until out_ready. A drain and a new load in the same cycle is allowed (single-entry register, so one triangle is in flight at the output).
- Throughput: at most one triangle per CLIP_LATENCY+1 cycles.
- Latency: accept edge A with the FIFO empty and S_IDLE → issue sampled at A+1 → out_valid high after edge A+CLIP_LATENCY+2, i.e. 9 cycles at the default.
- stat_in increments on every push.

Decomposition:
- Package clip_pkg: COORD_W, TRI_W = 12*COORD_W, CLIP_LATENCY, state encoding (S_IDLE, S_BUSY, S_CAPT), and pack/unpack functions for vertex fields.
- One sub-module, tri_fifo: synchronous FIFO, parameters WIDTH and DEPTH, ports push/pop/full/empty/head, asynchronous active-high reset.
- Controller FSM, counter, output register and stats stay in clip_scheduler.

Test Plan:
- Single in-frustum triangle (w=1; vertices (0,0,0), (0.5,0,0), (0,0.5,0)), out_ready=1 → one clip_valid_in pulse at A+1; out_valid at A+9; out_tri equal to input; stat_in=1, stat_out=1, stat_cull=0.
- Triangle fully outside (all x=5, w=1) → clip_valid_out=0 in capture; out_valid never asserts; stat_cull=1; busy drops to 0 at the end.
- Six back-to-back triangles, FIFO_DEPTH=4 → in_ready low after 4 buffered entries; issue pulses exactly 8 cycles apart; outputs in input order; stat_in=6.
- out_ready held low for 30 cycles after the first result → FSM stays in S_CAPT; no further clip_valid_in; out_tri stable; when released, the second result follows with correct ordering.
- rst pulsed mid-S_BUSY with 2 triangles queued → all outputs reach reset values asynchronously; FIFO empty; no out_valid afterwards.
- stat_clr in the same cycle as a push → stat_in reads 0 the next cycle.
